console_reset_sequencer: RTL and testbench
==========================================

Name: console_reset_sequencer

Overview:
- Board-level controller that sequences reset and the user buttons for the Atari 2600 core on the iCEBreaker.
- Waits for PLL lock, then applies a counted power-on reset and releases the core.
- Long-pressing the reset button re-asserts core reset. Buttons are synchronised and debounced, and a heartbeat LED is generated.
- Sits between the PLL / board pins and the core's rst_n and ui_in inputs.

Parameters:
- NUM_BTNS, 3: number of general user buttons (BTN1..BTN3).
- POR_CYCLES, 16: number of cycles core reset is held after lock or after a button reset; must be ≥1.
- HOLD_CYCLES, 25200000: number of continuous debounced-press cycles on the reset button needed to reset the core (1 s at 800x525x60).
- DEBOUNCE_CYCLES, 65536: number of cycles a synchronised input must be stable before its clean value changes; must be ≥1.
- BLINK_CYCLES, 25200000: half-period of heartbeat, in cycles.

Ports:
- clk_pixel  in  1  pixel clock (25.125 MHz); the single clock domain.
- reset  in  1  synchronous reset, active-high.
- pll_locked  in  1  PLL LOCK, asynchronous.
- btn_reset_n  in  1  raw reset button, active-low, asynchronous.
- btn_raw  in  NUM_BTNS  raw user buttons, active-high, asynchronous.
- core_rst_n  out  1  reset to the core, active-low, registered.
- btn_clean  out  NUM_BTNS  debounced user buttons.
- btn_rise  out  NUM_BTNS  one-cycle pulse on each 0->1 transition of btn_clean.
- reset_btn_clean  out  1  debounced reset button, active-high (pressed = 1).
- heartbeat  out  1  LED toggle signal.
- seq_state  out  2  current FSM state, for debug.

Behaviour:
- Reset is synchronous: while reset=1 at a clk_pixel edge, every output and register takes its reset value.
  - seq_state = S_LOCK (0).
  - core_rst_n = 0.
  - btn_clean = 0, btn_rise = 0, reset_btn_clean = 0, heartbeat = 0.
  - All counters = 0, all synchroniser flops = 0.
- Synchronisers:
  - pll_locked, ~btn_reset_n and each btn_raw bit each pass through a 2-FF synchroniser.
  - The reset-button synchroniser resets to "released".
- Debounce, per channel:
  - The counter clears whenever the synchronised value equals the current clean value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the clean value takes the synchronised value on that edge and the counter clears.
  - A raw change held steady appears on the clean output DEBOUNCE_CYCLES+2 edges after it is first sampled.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never reach the clean output.
- btn_rise: registered so it is high in exactly the cycle where btn_clean first reads 1.
- FSM states:
  - S_LOCK (0): core_rst_n = 0. When synced lock = 1 → S_POR with the POR counter at 0.
  - S_POR (1): core_rst_n = 0. The counter increments each cycle; when it equals POR_CYCLES-1 → S_RUN.
  - S_RUN (2): core_rst_n = 1.
    - The hold counter increments each cycle reset_btn_clean = 1 and clears when it is 0.
    - When the hold counter equals HOLD_CYCLES-1 → S_BTN and the hold counter clears.
  - S_BTN (3): core_rst_n = 0. Stays while reset_btn_clean = 1; on 0 → S_POR with the POR counter at 0.
- core_rst_n is registered as (next state == S_RUN).
  - From the first edge sampling pll_locked = 1, core_rst_n rises after exactly 3+POR_CYCLES edges.
- Counter widths: each counter is $clog2(limit) bits. Counters never wrap because each one is cleared on its terminal value.
- Short press of the reset button (shorter than HOLD_CYCLES): no effect on core_rst_n.
- Heartbeat:
  - The blink counter runs only in S_RUN and is cleared in all other states.
  - heartbeat toggles on the edge where the counter equals BLINK_CYCLES-1, and the counter clears on that same edge.
  - heartbeat is forced to 0 outside S_RUN.
- Reset mid-operation (any state, any counter value): the block returns to S_LOCK on the next edge. A debounce in progress is discarded.

Optional Feature:
- Macro: CONSOLE_SEQ_LOCK_MONITOR_EN.
- Defined: in S_POR, S_RUN and S_BTN, synced lock = 0 forces → S_LOCK on the next edge, with core_rst_n = 0 on that edge and all counters cleared. This takes priority over the other transitions.
- Undefined: pll_locked is examined only in S_LOCK, and later loss of lock is ignored.

Test Plan (POR_CYCLES=4, HOLD_CYCLES=10, DEBOUNCE_CYCLES=3, BLINK_CYCLES=8, NUM_BTNS=3):
- Power-up: reset for 2 cycles, then pll_locked=1 at edge 0 → core_rst_n=0 through edge 6 and 1 from edge 7; seq_state goes 0 → 1 → 2.
- Debounce: btn_raw[0] high for 2 cycles → btn_clean stays 0. Then held high → btn_clean[0]=1 at edge 5 after the rise, with btn_rise[0]=1 for exactly that one cycle.
- Long press: in S_RUN, btn_reset_n=0 held → reset_btn_clean rises, then 10 cycles later seq_state=3 and core_rst_n=0. On release, core_rst_n returns to 1 after debounce+5 edges.
- Short press: btn_reset_n=0 for 8 cycles in S_RUN → core_rst_n remains 1 and the hold counter returns to 0.
- Heartbeat: 32 cycles in S_RUN → heartbeat toggles every 8 cycles (4 toggles). Entering S_BTN → heartbeat=0 immediately.
- Lock loss with CONSOLE_SEQ_LOCK_MONITOR_EN: drop pll_locked in S_RUN → S_LOCK and core_rst_n=0 3 edges later. Without the macro, core_rst_n stays 1.

Source files
------------

// File: rtl/console_reset_sequencer.sv
// Reset and button sequencer for the Atari 2600 core: PLL-lock wait, counted power-on reset,
// long-press reset, button debounce and heartbeat. Optional lock-loss monitor: CONSOLE_SEQ_LOCK_MONITOR_EN.
//
// state  | meaning
// S_LOCK | waiting for synchronised PLL lock, core held in reset
// S_POR  | counting POR_CYCLES with core held in reset
// S_RUN  | core released, heartbeat running, watching for a long reset press
// S_BTN  | long press detected, core held until the reset button is released
module console_reset_sequencer #(
  parameter int NUM_BTNS        = 3,
  parameter int POR_CYCLES      = 16,
  parameter int HOLD_CYCLES     = 25200000,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_CYCLES    = 25200000
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                btn_reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic                core_rst_n,
  output logic [NUM_BTNS-1:0] btn_clean,
  output logic [NUM_BTNS-1:0] btn_rise,
  output logic                reset_btn_clean,
  output logic                heartbeat,
  output logic [1:0]          seq_state
);

  localparam int NCH = NUM_BTNS + 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  POR_LAST   = PW'(POR_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOCK = 2'd0,
    S_POR  = 2'd1,
    S_RUN  = 2'd2,
    S_BTN  = 2'd3
  } state_t;

  // Reset button occupies the top channel so it shares the debounce path.
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] in_s1, in_s2;
  logic           lock_s1, lock_s2;

  assign raw_in = {~btn_reset_n, btn_raw};

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      in_s1   <= '0;
      in_s2   <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      in_s1   <= raw_in;
      in_s2   <= in_s1;
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  logic [NCH-1:0] clean_q, clean_d, db_tc;
  logic [DBW-1:0] db_cnt [NCH];

  always_comb begin
    db_tc = '0;
    for (int i = 0; i < NCH; i++) begin
      db_tc[i] = (in_s2[i] != clean_q[i]) && (db_cnt[i] == DB_LAST);
    end
    clean_d = clean_q ^ db_tc;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      clean_q  <= '0;
      btn_rise <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_s2[i] == clean_q[i] || db_tc[i]) db_cnt[i] <= '0;
        else                                     db_cnt[i] <= db_cnt[i] + 1'b1;
      end
      clean_q  <= clean_d;
      btn_rise <= clean_d[NUM_BTNS-1:0] & ~clean_q[NUM_BTNS-1:0];
    end
  end

  assign btn_clean       = clean_q[NUM_BTNS-1:0];
  assign reset_btn_clean = clean_q[NUM_BTNS];

  state_t        state, state_d;
  logic [PW-1:0] por_cnt;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic          lock_lost;

`ifdef CONSOLE_SEQ_LOCK_MONITOR_EN
  assign lock_lost = ~lock_s2;
`else
  assign lock_lost = 1'b0;
`endif

  always_comb begin
    state_d = state;
    if (state != S_LOCK && lock_lost) begin
      state_d = S_LOCK;
    end else begin
      case (state)
        S_LOCK:  if (lock_s2) state_d = S_POR;
        S_POR:   if (por_cnt == POR_LAST) state_d = S_RUN;
        S_RUN:   if (reset_btn_clean && hold_cnt == HOLD_LAST) state_d = S_BTN;
        S_BTN:   if (!reset_btn_clean) state_d = S_POR;
        default: state_d = S_LOCK;
      endcase
    end
  end

  // Every counter clears whenever its state is entered or left, so none can wrap.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state      <= S_LOCK;
      por_cnt    <= '0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      core_rst_n <= 1'b0;
      heartbeat  <= 1'b0;
    end else begin
      state      <= state_d;
      core_rst_n <= (state_d == S_RUN);
      por_cnt    <= (state == S_POR && state_d == S_POR) ? por_cnt + 1'b1 : '0;
      hold_cnt   <= (state == S_RUN && state_d == S_RUN && reset_btn_clean) ? hold_cnt + 1'b1 : '0;
      if (state == S_RUN && state_d == S_RUN) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          heartbeat <= ~heartbeat;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        heartbeat <= 1'b0;
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_console_reset_sequencer.sv
// Bench for console_reset_sequencer: directed boundary checks plus a randomized run scored
// every cycle against a history-based reference model.
module tb_console_reset_sequencer;
  localparam int NB    = 3;
  localparam int POR   = 4;
  localparam int HOLD  = 10;
  localparam int DEB   = 3;
  localparam int BLINK = 8;
  localparam int NCH   = NB + 1;
  localparam int MAXC  = 4096;

  logic          clk_pixel = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          btn_reset_n = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic          core_rst_n;
  logic [NB-1:0] btn_clean, btn_rise;
  logic          reset_btn_clean, heartbeat;
  logic [1:0]    seq_state;

  console_reset_sequencer #(
    .NUM_BTNS(NB), .POR_CYCLES(POR), .HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .pll_locked(pll_locked),
    .btn_reset_n(btn_reset_n), .btn_raw(btn_raw), .core_rst_n(core_rst_n),
    .btn_clean(btn_clean), .btn_rise(btn_rise), .reset_btn_clean(reset_btn_clean),
    .heartbeat(heartbeat), .seq_state(seq_state)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: input histories indexed by edge number since reset release.
  typedef logic [10:0] obs_t;  // {core_rst_n, seq_state, btn_clean, btn_rise, reset_btn_clean, heartbeat}
  obs_t           exp_q[$];
  bit [NCH-1:0]   raw_h [MAXC];
  bit             lock_h [MAXC];
  bit [NCH-1:0]   m_clean;
  int             t, m_mode, por_entry, run_entry, hold_run;

  function automatic bit sync_ch(input int u, input int c);
    return (u >= 2) ? raw_h[u-2][c] : 1'b0;
  endfunction

  task automatic model_step();
    bit [NCH-1:0] prev, nclean;
    bit [NB-1:0]  rise;
    bit           s_lock, rbtn, lost, hb, all_diff;
    int           nm;
    if (reset) begin
      t = -1; m_clean = '0; m_mode = 0; por_entry = 0; run_entry = 0; hold_run = 0;
      exp_q.push_back('0);
      return;
    end
    t++;
    if (t >= MAXC) begin
      $display("FAIL model_history: overflow at edge %0d", t);
      $fatal(1);
    end
    raw_h[t]  = {~btn_reset_n, btn_raw};
    lock_h[t] = pll_locked;
    prev   = m_clean;
    nclean = prev;
    // A clean value flips once the last DEB synchronised samples all disagree with it.
    for (int c = 0; c < NCH; c++) begin
      if (t - DEB + 1 >= 0) begin
        all_diff = 1'b1;
        for (int u = t - DEB + 1; u <= t; u++) if (sync_ch(u, c) == prev[c]) all_diff = 1'b0;
        if (all_diff) nclean[c] = ~prev[c];
      end
    end
    s_lock = (t >= 2) ? lock_h[t-2] : 1'b0;
    rbtn   = prev[NB];
    nm     = m_mode;
    lost   = 1'b0;
`ifdef CONSOLE_SEQ_LOCK_MONITOR_EN
    lost = (m_mode != 0) && !s_lock;
`endif
    if (lost) nm = 0;
    else begin
      case (m_mode)
        0: if (s_lock) begin nm = 1; por_entry = t; end
        1: if (t - por_entry == POR) begin nm = 2; run_entry = t; hold_run = 0; end
        2: begin
          hold_run = rbtn ? hold_run + 1 : 0;
          if (hold_run == HOLD) nm = 3;
        end
        default: if (!rbtn) begin nm = 1; por_entry = t; end
      endcase
    end
    hb   = (nm == 2) ? (((t - run_entry) / BLINK) % 2 == 1) : 1'b0;
    rise = nclean[NB-1:0] & ~prev[NB-1:0];
    m_clean = nclean;
    m_mode  = nm;
    exp_q.push_back({nm == 2, 2'(nm), nclean[NB-1:0], rise, nclean[NB], hb});
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    model_step();
    #1;
  endtask

  int btn_left [NB];
  int rb_left, lk_left, toggles, any_hi, min_core;
  bit prev_hb;
  obs_t got_o, exp_o;

  initial begin
    fork
      forever begin
        @(negedge clk_pixel);
        if (exp_q.size() > 0) begin
          exp_o = exp_q.pop_front();
          got_o = {core_rst_n, seq_state, btn_clean, btn_rise, reset_btn_clean, heartbeat};
          n_checks++;
          if (got_o !== exp_o) begin
            n_errors++;
            $display("FAIL scoreboard at %0t {core,state,clean,rise,rclean,hb}: got %b expected %b",
                     $time, got_o, exp_o);
          end
        end
      end
    join_none

    // Power-up
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("reset_state", int'(seq_state), 0);
    check("reset_core", int'(core_rst_n), 0);
    pll_locked = 1'b1;
    repeat (6) tick();
    check("por_core_low", int'(core_rst_n), 0);
    check("por_state", int'(seq_state), 1);
    tick();
    check("por_core_high", int'(core_rst_n), 1);
    check("run_state", int'(seq_state), 2);

    // Debounce: short pulse filtered, held press appears on the 5th edge
    btn_raw[0] = 1'b1; tick(); tick(); btn_raw[0] = 1'b0;
    any_hi = 0;
    repeat (6) begin tick(); if (btn_clean[0]) any_hi = 1; end
    check("short_pulse_filtered", any_hi, 0);
    btn_raw[0] = 1'b1;
    repeat (4) tick();
    check("deb_before", int'(btn_clean[0]), 0);
    tick();
    check("deb_clean", int'(btn_clean[0]), 1);
    check("deb_rise", int'(btn_rise[0]), 1);
    tick();
    check("deb_rise_once", int'(btn_rise[0]), 0);
    btn_raw[0] = 1'b0;
    repeat (6) tick();

    // Long press
    btn_reset_n = 1'b0;
    repeat (4) tick();
    check("rbtn_before", int'(reset_btn_clean), 0);
    tick();
    check("rbtn_clean", int'(reset_btn_clean), 1);
    repeat (9) tick();
    check("hold_not_yet", int'(seq_state), 2);
    tick();
    check("hold_btn_state", int'(seq_state), 3);
    check("hold_core", int'(core_rst_n), 0);
    check("hold_hb", int'(heartbeat), 0);
    btn_reset_n = 1'b1;
    repeat (9) tick();
    check("release_core_low", int'(core_rst_n), 0);
    tick();
    check("release_core_high", int'(core_rst_n), 1);

    // Heartbeat over 32 cycles of S_RUN
    toggles = 0; prev_hb = heartbeat;
    repeat (32) begin tick(); if (heartbeat != prev_hb) toggles++; prev_hb = heartbeat; end
    check("hb_toggles", toggles, 4);

    // Short press: no reset
    btn_reset_n = 1'b0; repeat (8) tick(); btn_reset_n = 1'b1;
    min_core = 1;
    repeat (12) begin tick(); if (!core_rst_n) min_core = 0; end
    check("short_press_core", min_core, 1);

    // Lock loss
    pll_locked = 1'b0; tick(); tick();
    check("lock_loss_e2", int'(core_rst_n), 1);
    tick();
`ifdef CONSOLE_SEQ_LOCK_MONITOR_EN
    check("lock_loss_core", int'(core_rst_n), 0);
    check("lock_loss_state", int'(seq_state), 0);
`else
    check("lock_loss_core", int'(core_rst_n), 1);
    check("lock_loss_state", int'(seq_state), 2);
`endif
    pll_locked = 1'b1; repeat (10) tick();

    // Mid-run reset
    repeat ($urandom_range(1, 7)) tick();
    reset = 1'b1; tick();
    check("midrun_reset_state", int'(seq_state), 0);
    check("midrun_reset_core", int'(core_rst_n), 0);
    reset = 1'b0;
    repeat (8) tick();
    check("midrun_recover", int'(core_rst_n), 1);

    // Randomized traffic
    for (int c = 0; c < NB; c++) btn_left[c] = 0;
    rb_left = 10; lk_left = 100;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (btn_left[c] == 0) begin
          btn_raw[c]  = 1'($urandom_range(0, 1));
          btn_left[c] = $urandom_range(1, 6);
        end
        btn_left[c]--;
      end
      if (rb_left == 0) begin
        if (!btn_reset_n) begin btn_reset_n = 1'b1; rb_left = $urandom_range(5, 40); end
        else              begin btn_reset_n = 1'b0; rb_left = $urandom_range(1, 20); end
      end
      rb_left--;
      if (lk_left == 0) begin
        if (pll_locked) begin pll_locked = 1'b0; lk_left = $urandom_range(1, 4); end
        else            begin pll_locked = 1'b1; lk_left = $urandom_range(60, 300); end
      end
      lk_left--;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk_pixel);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
